// File: rtl/siggen_pwm_dac.sv
// rtl/siggen_pwm_dac.sv - single-pin DAC stage: attenuated, period-buffered PWM or sigma-delta
// Consumes the generator's sample bus and drives one pin for an RC filter.
module siggen_pwm_dac #(
  parameter int WIDTH   = 8,
  parameter int ATTEN_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [WIDTH-1:0]   sample_in,
  input  logic [ATTEN_W-1:0] atten,
  input  logic               dac_mode,
  output logic               pwm_out,
  output logic               period_start,
  output logic [WIDTH-1:0]   level_out
);

  localparam logic [WIDTH-1:0] MID     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             pwm_q, pwm_d;
  logic             ps_q, ps_d;

  logic signed [WIDTH:0] diff;
  logic signed [WIDTH:0] shifted;
  logic [WIDTH-1:0]      scaled;
  logic [WIDTH:0]        sd_sum;

  always_comb begin
    diff    = $signed({1'b0, sample_in}) - $signed({1'b0, MID});
    shifted = diff >>> atten;
    // Shifting toward midscale can only shrink |diff|, so the sum never leaves 0..2**WIDTH-1
    scaled  = MID + shifted[WIDTH-1:0];
    sd_sum  = {1'b0, acc_q} + {1'b0, level_q};

    cnt_d   = cnt_q;
    level_d = level_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    pwm_d   = pwm_q;
    ps_d    = ps_q;

    if (!enable) begin
      cnt_d = CNT_MAX;
      acc_d = '0;
      pwm_d = 1'b0;
      ps_d  = 1'b0;
    end else begin
      cnt_d = cnt_q + 1'b1;
      ps_d  = (cnt_q == '0);
      if (!mode_q) begin
        pwm_d = (cnt_q < level_q);
      end else begin
        pwm_d = sd_sum[WIDTH];
        acc_d = sd_sum[WIDTH-1:0];
      end
      if (cnt_q == CNT_MAX) begin
        level_d = scaled;
        mode_d  = dac_mode;
        if (dac_mode != mode_q) acc_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= CNT_MAX;
      level_q <= MID;
      mode_q  <= 1'b0;
      acc_q   <= '0;
      pwm_q   <= 1'b0;
      ps_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      pwm_q   <= pwm_d;
      ps_q    <= ps_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;
  assign level_out    = level_q;

endmodule

// File: tb/tb_siggen_pwm_dac.sv
// tb/tb_siggen_pwm_dac.sv - self-checking bench for siggen_pwm_dac
module tb_siggen_pwm_dac;

  logic       clk = 1'b0;
  logic       rst, enable, dac_mode;
  logic [7:0] sample_in;
  logic [1:0] atten;
  logic       pwm_out, period_start;
  logic [7:0] level_out;

  int n_vec = 0;
  int n_bad = 0;

  int m_cnt = 255, m_level = 128, m_mode = 0, m_acc = 0, m_pwm = 0, m_ps = 0;

  always #5 clk = ~clk;

  siggen_pwm_dac #(.WIDTH(8), .ATTEN_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_in    (sample_in),
    .atten        (atten),
    .dac_mode     (dac_mode),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .level_out    (level_out)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Midscale-centred attenuation as floor division of the signed offset
  function automatic int ref_scale(input int s, input int a);
    int d;
    int p;
    d = s - 128;
    p = 1 << a;
    if (d >= 0) return 128 + d / p;
    return 128 - ((-d + p - 1) / p);
  endfunction

  task automatic model_step();
    if (rst) begin
      m_cnt = 255; m_level = 128; m_mode = 0; m_acc = 0; m_pwm = 0; m_ps = 0;
    end else if (!enable) begin
      m_cnt = 255; m_acc = 0; m_pwm = 0; m_ps = 0;
    end else begin
      m_ps = (m_cnt == 0) ? 1 : 0;
      if (m_mode == 0) begin
        m_pwm = (m_cnt < m_level) ? 1 : 0;
      end else begin
        m_acc = m_acc + m_level;
        m_pwm = (m_acc >= 256) ? 1 : 0;
        m_acc = m_acc % 256;
      end
      if (m_cnt == 255) begin
        if (int'(dac_mode) != m_mode) m_acc = 0;
        m_mode  = int'(dac_mode);
        m_level = ref_scale(int'(sample_in), int'(atten));
      end
      m_cnt = (m_cnt + 1) % 256;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("pwm_out", int'(pwm_out), m_pwm);
    check("period_start", int'(period_start), m_ps);
    check("level_out", int'(level_out), m_level);
  endtask

  // Measures one full period starting at a period_start cycle; optionally changes sample mid-period
  task automatic count_period(output int highs, input int change_at, input int new_sample,
                              input bit chk_contig);
    int  w;
    bit  seen_low;
    bit  contiguous;
    w = 0;
    seen_low = 1'b0;
    contiguous = 1'b1;
    highs = 0;
    while (period_start !== 1'b1 && w < 600) begin
      tick();
      w++;
    end
    if (period_start !== 1'b1) begin
      check("ps_timeout", 0, 1);
      highs = -1;
      return;
    end
    for (int i = 0; i < 256; i++) begin
      if (i == change_at) sample_in = new_sample[7:0];
      if (pwm_out === 1'b1) begin
        highs++;
        if (seen_low) contiguous = 1'b0;
      end else begin
        seen_low = 1'b1;
      end
      tick();
    end
    check("period_len", int'(period_start), 1);
    if (chk_contig) check("contiguous", int'(contiguous), 1);
  endtask

  initial begin
    int h;
    rst = 1'b1; enable = 1'b1; sample_in = 8'hFF; atten = 2'd0; dac_mode = 1'b0;
    repeat (3) tick();
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_ps", int'(period_start), 0);
    check("rst_level", int'(level_out), 128);

    rst = 1'b0; sample_in = 8'h40;
    count_period(h, -1, 0, 1'b1); check("pwm64_a", h, 64);
    count_period(h, -1, 0, 1'b1); check("pwm64_b", h, 64);

    sample_in = 8'h00;
    count_period(h, -1, 0, 1'b1); check("pwm64_flush", h, 64);
    count_period(h, -1, 0, 1'b1); check("pwm_zero", h, 0);
    sample_in = 8'hFF;
    count_period(h, -1, 0, 1'b1); check("pwm_zero_flush", h, 0);
    count_period(h, -1, 0, 1'b1); check("pwm_full", h, 255);

    atten = 2'd2;
    count_period(h, -1, 0, 1'b1); check("pwm_full_flush", h, 255);
    count_period(h, -1, 0, 1'b1); check("atten_ff_highs", h, 159);
    check("atten_ff_level", int'(level_out), 159);
    sample_in = 8'h00;
    count_period(h, -1, 0, 1'b1); check("atten_ff_flush", h, 159);
    count_period(h, -1, 0, 1'b1); check("atten_00_highs", h, 96);
    check("atten_00_level", int'(level_out), 96);

    atten = 2'd0; sample_in = 8'h40;
    count_period(h, -1, 0, 1'b1);
    count_period(h, -1, 0, 1'b1); check("pre_change", h, 64);
    count_period(h, 100, 8'hC0, 1'b1); check("mid_change_cur", h, 64);
    count_period(h, -1, 0, 1'b1); check("mid_change_next", h, 192);

    dac_mode = 1'b1; sample_in = 8'h80;
    count_period(h, -1, 0, 1'b1); check("pre_sd", h, 192);
    for (int i = 0; i < 8; i++) begin
      check("sd_alt", int'(pwm_out), i % 2);
      tick();
    end
    rst = 1'b1;
    tick();
    check("midrst_pwm", int'(pwm_out), 0);
    check("midrst_ps", int'(period_start), 0);
    check("midrst_level", int'(level_out), 128);
    rst = 1'b0; dac_mode = 1'b0; sample_in = 8'h40;
    count_period(h, -1, 0, 1'b1); check("post_rst_pwm", h, 64);

    repeat (30) tick();
    enable = 1'b0;
    tick();
    check("dis_pwm", int'(pwm_out), 0);
    repeat (5) tick();
    check("dis_level", int'(level_out), 64);
    enable = 1'b1;

    repeat (4000) begin
      if ($urandom_range(0, 99) < 3) sample_in = 8'($urandom);
      if ($urandom_range(0, 99) < 1) atten = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) < 1) dac_mode = ~dac_mode;
      if ($urandom_range(0, 199) < 1) enable = ~enable;
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
